// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned FETCH_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]           inst;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO with flush, occupancy count and a
// head taken directly from the storage registers.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              push,
    input  logic [31:0]                       push_inst,
    input  logic [XLEN-1:0]                   push_pc,
    input  logic                              pop,
    output logic [$clog2(FIFO_DEPTH):0]       count,
    output logic                              head_valid,
    output logic [31:0]                       head_inst,
    output logic [XLEN-1:0]                   head_pc
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]     inst_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt;
    logic            do_pop;

    assign do_pop = pop && (cnt != '0);

    // A push into a full FIFO is legal only when the head leaves in the same
    // cycle; the write then lands in the slot being vacated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                inst_mem[wr_ptr] <= push_inst;
                pc_mem[wr_ptr]   <= push_pc;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (!push && do_pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign count      = cnt;
    assign head_valid = (cnt != '0);
    assign head_inst  = inst_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && !do_pop && (cnt == CW'(FIFO_DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order imem requests, PC-tagged
// response buffer, redirect with drop-counting. FETCH_STATS_EN adds counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_data_o,
    output logic [XLEN-1:0] inst_pc_o
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_fetched_o,
    output logic [31:0]     stat_dropped_o
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_target;
    logic [CW-1:0]   outstanding, outstanding_next;
    logic [CW-1:0]   drop_cnt, drop_cnt_next;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            req_fire, rsp_drop, push, inst_pop;

    assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_addr_o = fetch_pc;
    assign inst_pop        = inst_valid_o && inst_ready_i;

    // On redirect nothing is issued, so every request still in flight after
    // this cycle's response (which is itself discarded) must be dropped.
    always_comb begin
        state_next       = state;
        imem_req_valid_o = (state != IDLE) && !redirect_i &&
                           (credit_used < (CW+1)'(FIFO_DEPTH));
        req_fire         = imem_req_valid_o && imem_req_ready_i;
        outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid_i);
        rsp_drop         = imem_rsp_valid_i && (redirect_i || (drop_cnt != '0));
        push             = imem_rsp_valid_i && !rsp_drop;
        drop_cnt_next    = drop_cnt;
        if (redirect_i) begin
            drop_cnt_next = outstanding_next;
        end else if (imem_rsp_valid_i && (drop_cnt != '0)) begin
            drop_cnt_next = drop_cnt - 1'b1;
        end
        case (state)
            IDLE:    state_next = RUN;
            RUN:     if (redirect_i && (outstanding_next != '0)) state_next = DRAIN;
            DRAIN:   if (drop_cnt_next == '0) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
            if (redirect_i) begin
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
                if (push)     rsp_pc   <= rsp_pc + XLEN'(INST_BYTES);
            end
        end
    end

    fetch_fifo #(
        .XLEN       (XLEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RST_N),
        .flush      (redirect_i),
        .push       (push),
        .push_inst  (imem_rsp_data_i),
        .push_pc    (rsp_pc),
        .pop        (inst_pop),
        .count      (fifo_count),
        .head_valid (inst_valid_o),
        .head_inst  (inst_data_o),
        .head_pc    (inst_pc_o)
    );

`ifdef FETCH_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stat_fetched_o <= '0;
            stat_dropped_o <= '0;
        end else begin
            if (push && (stat_fetched_o != '1)) stat_fetched_o <= stat_fetched_o + 1'b1;
            if (rsp_drop && (stat_dropped_o != '1)) stat_dropped_o <= stat_dropped_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model plus expected-instruction
// scoreboard, immediate assertions at every comparison point.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_data_o;
    logic [31:0] inst_pc_o;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_o;
    logic [31:0] stat_dropped_o;
`endif

    fetch_unit #(
        .XLEN       (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_data_o      (inst_data_o),
        .inst_pc_o        (inst_pc_o)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched_o   (stat_fetched_o),
        .stat_dropped_o   (stat_dropped_o)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] inst; logic [31:0] pc; } exp_t;
    typedef struct { logic [31:0] addr; int unsigned due; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] got_pc[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned req_cnt  = 0;
    int unsigned n_edge   = 0;
    int unsigned lat      = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_got(input int unsigned n, input string tag);
        int unsigned t = 0;
        while (got_pc.size() < n && t < 100) begin
            tick();
            t++;
        end
        checks++;
        assert (got_pc.size() >= n) else begin
            failures++;
            $error("FAIL %s delivered=%0d expected=%0d", tag, got_pc.size(), n);
        end
    endtask

    task automatic do_reset();
        RST_N      = 1'b0;
        redirect_i = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N   = 1'b1;
        req_cnt = 0;
    endtask

    // Memory model and scoreboard, acting half a cycle away from the DUT edge.
    initial begin
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        forever begin
            @(negedge CLK);
            n_edge++;
            if (!RST_N) begin
                pend_q.delete();
                exp_q.delete();
                imem_rsp_valid_i = 1'b0;
                imem_rsp_data_i  = '0;
            end else begin
                if (inst_valid_o && inst_ready_i) begin
                    got_pc.push_back(inst_pc_o);
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        failures++;
                        $error("FAIL sb_underflow observed_pc=%h expected=queued_entry", inst_pc_o);
                    end
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("sb_pc", inst_pc_o, e.pc);
                        chk("sb_data", inst_data_o, e.inst);
                    end
                end
                if (redirect_i) begin
                    chk("no_req_in_redirect", 32'(imem_req_valid_o), 32'd0);
                    exp_q.delete();
                end
                imem_rsp_valid_i = 1'b0;
                imem_rsp_data_i  = '0;
                if (pend_q.size() > 0 && pend_q[0].due <= n_edge) begin
                    pend_t p;
                    p = pend_q.pop_front();
                    imem_rsp_valid_i = 1'b1;
                    imem_rsp_data_i  = mem_word(p.addr);
                end
                if (imem_req_valid_o && imem_req_ready_i) begin
                    pend_q.push_back('{addr: imem_req_addr_o, due: n_edge + lat});
                    exp_q.push_back('{inst: mem_word(imem_req_addr_o), pc: imem_req_addr_o});
                    req_cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N            = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        imem_req_ready_i = 1'b1;
        inst_ready_i     = 1'b1;

        // Reset state and boot sequence, L=1
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst_data", inst_data_o, 32'd0);
        chk("rst_inst_pc", inst_pc_o, 32'd0);
        RST_N   = 1'b1;
        req_cnt = 0;
        got_pc.delete();
        chk("idle_no_req", 32'(imem_req_valid_o), 32'd0);
        tick();
        chk("boot_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("boot_req_addr", imem_req_addr_o, 32'h0);
        tick();
        chk("boot_latency_early", 32'(inst_valid_o), 32'd0);
        tick();
        chk("boot_latency_valid", 32'(inst_valid_o), 32'd1);
        chk("boot_head_pc", inst_pc_o, 32'h0);
        chk("boot_head_data", inst_data_o, mem_word(32'h0));
        wait_got(3, "boot_deliver");
        for (int i = 0; i < 3; i++) chk("boot_pc_seq", got_pc[i], 32'(4 * i));

        // Backpressure: decode stalled, credits cap requests at FIFO depth
        inst_ready_i = 1'b0;
        do_reset();
        repeat (12) tick();
        chk("bp_req_count", 32'(req_cnt), 32'd4);
        chk("bp_req_stopped", 32'(imem_req_valid_o), 32'd0);
        chk("bp_head_pc", inst_pc_o, 32'h0);
        got_pc.delete();
        inst_ready_i = 1'b1;
        wait_got(8, "bp_resume");
        for (int i = 0; i < 8; i++) chk("bp_pc_seq", got_pc[i], 32'(4 * i));

        // Redirect with two requests in flight, L=3
        lat              = 3;
        imem_req_ready_i = 1'b0;
        do_reset();
        tick();
        imem_req_ready_i = 1'b1;
        tick();
        tick();
        imem_req_ready_i = 1'b0;
        redirect_i       = 1'b1;
        redirect_pc_i    = 32'h0000_0100;
        got_pc.delete();
        tick();
        redirect_i       = 1'b0;
        imem_req_ready_i = 1'b1;
        wait_got(2, "redir_deliver");
        chk("redir_first_pc", got_pc[0], 32'h100);
        chk("redir_second_pc", got_pc[1], 32'h104);
`ifdef FETCH_STATS_EN
        chk("stat_dropped_redir", stat_dropped_o, 32'd2);
`endif

        // Misaligned target and address wrap, L=1
        imem_req_ready_i = 1'b0;
        repeat (8) tick();
        lat              = 1;
        imem_req_ready_i = 1'b1;
        redirect_i       = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFE;
        got_pc.delete();
        tick();
        redirect_i = 1'b0;
        #1;
        chk("wrap_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("wrap_req_addr", imem_req_addr_o, 32'hFFFF_FFFC);
        wait_got(2, "wrap_deliver");
        chk("wrap_first_pc", got_pc[0], 32'hFFFF_FFFC);
        chk("wrap_second_pc", got_pc[1], 32'h0000_0000);

        // Redirect coinciding with a response that would refill the buffer
        inst_ready_i = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("sim_full_valid", 32'(inst_valid_o), 32'd1);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        #1;
        chk("sim_req_blocked", 32'(imem_req_valid_o), 32'd0);
        chk("sim_head_before", 32'(inst_valid_o), 32'd1);
        got_pc.delete();
        tick();
        redirect_i = 1'b0;
        chk("sim_flushed", 32'(inst_valid_o), 32'd0);
        inst_ready_i = 1'b1;
        wait_got(1, "sim_deliver");
        chk("sim_first_pc", got_pc[0], 32'h200);
`ifdef FETCH_STATS_EN
        chk("stat_dropped_sim", stat_dropped_o, 32'd1);
`endif

        // Asynchronous reset while draining
        lat              = 3;
        imem_req_ready_i = 1'b0;
        do_reset();
        tick();
        imem_req_ready_i = 1'b1;
        tick();
        tick();
        imem_req_ready_i = 1'b0;
        redirect_i       = 1'b1;
        redirect_pc_i    = 32'h0000_0300;
        tick();
        redirect_i = 1'b0;
        #1;
        chk("drain_req_valid", 32'(imem_req_valid_o), 32'd1);
        #1;
        RST_N = 1'b0;
        #1;
        chk("arst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("arst_inst_valid", 32'(inst_valid_o), 32'd0);
`ifdef FETCH_STATS_EN
        chk("arst_stat_fetched", stat_fetched_o, 32'd0);
        chk("arst_stat_dropped", stat_dropped_o, 32'd0);
`endif
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
